result_display_driver: RTL and testbench

- Downstream consumer of the 8-bit add/subtract stage.
- Captures a two's-complement result and its overflow flag on a load strobe.
- Converts the result to sign plus magnitude, then to BCD using a sequential double-dabble.
- Time-multiplexes the result onto a 4-digit common-anode 7-segment display (active-low anodes and segments).

---
 rtl/result_display_pkg.sv | 46 ++++
 rtl/result_display_driver_bin2bcd.sv | 48 ++++
 rtl/result_display_driver.sv | 108 ++++++++++
 tb/tb_result_display_driver.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// Shared segment codes, FSM encoding and BCD-to-segment helper
// for the result display driver.
package result_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/result_display_driver_bin2bcd.sv
// 8-bit to 3-digit BCD, one double-dabble step per cycle.
// done is high during the final step; bcd is valid the cycle after.
module bin2bcd_seq
  import result_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  sh;
  logic [2:0]  cnt;
  logic        active;
  logic [11:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign done = active && (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= 3'd0;
      sh     <= 8'd0;
      bcd    <= 12'd0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= 3'd0;
      sh     <= bin;
      bcd    <= 12'd0;
    end else if (active) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt + 3'd1;
      if (cnt == 3'd7)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/result_display_driver.sv
// Captures an adder result, converts it to signed decimal and
// scans it onto a 4-digit common-anode 7-segment display.
module result_display_driver
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] res,
  input  logic       ovfl,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t      state, nstate;
  logic        neg, ovfl_q, start, done;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic [6:0]  dig [4];
  logic [6:0]  nd  [4];
  logic [CW-1:0] rcnt;
  logic [1:0]  idx;

  assign start = (state == IDLE) && load;
  assign mag   = res[7] ? (~res + 8'd1) : res;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (load) nstate = CONV;
      CONV:    if (done) nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Leading-zero suppression; the ones digit is always shown.
  always_comb begin
    nd[3] = neg ? SEG_MINUS : SEG_BLANK;
    nd[2] = (bcd[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(bcd[11:8]);
    nd[1] = (bcd[11:4] == 8'd0) ? SEG_BLANK : bcd_to_seg(bcd[7:4]);
    nd[0] = bcd_to_seg(bcd[3:0]);
    if (ovfl_q) begin
      nd[3] = SEG_BLANK;
      nd[2] = SEG_E;
      nd[1] = SEG_R;
      nd[0] = SEG_R;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      neg    <= 1'b0;
      ovfl_q <= 1'b0;
      dig[3] <= SEG_BLANK;
      dig[2] <= SEG_BLANK;
      dig[1] <= SEG_BLANK;
      dig[0] <= SEG_0;
    end else begin
      state <= nstate;
      if (start) begin
        neg    <= res[7];
        ovfl_q <= ovfl;
        busy   <= 1'b1;
      end
      if (state == COMMIT) begin
        busy <= 1'b0;
        for (int i = 0; i < 4; i++)
          dig[i] <= nd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= 2'd0;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dig[idx];
      if (rcnt == CW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        rcnt <= rcnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with a fast scan rate.
module tb_result_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] res;
  logic       ovfl;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  logic [7:0] got [4];

  always #5 clk = ~clk;

  result_display_driver #(.REFRESH_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .res  (res),
    .ovfl (ovfl),
    .busy (busy),
    .an   (an),
    .seg  (seg)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic collect();
    for (int i = 0; i < 4; i++) got[i] = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: got[0] = {1'b0, seg};
        4'b1101: got[1] = {1'b0, seg};
        4'b1011: got[2] = {1'b0, seg};
        4'b0111: got[3] = {1'b0, seg};
        default: chk("an_onehot", {28'd0, an}, 32'hE);
      endcase
    end
  endtask

  task automatic expect_digits(input string tag, input logic [6:0] e3,
                               input logic [6:0] e2, input logic [6:0] e1,
                               input logic [6:0] e0);
    collect();
    chk({tag, "_d3"}, {24'd0, got[3]}, {25'd0, e3});
    chk({tag, "_d2"}, {24'd0, got[2]}, {25'd0, e2});
    chk({tag, "_d1"}, {24'd0, got[1]}, {25'd0, e1});
    chk({tag, "_d0"}, {24'd0, got[0]}, {25'd0, e0});
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_load(input logic [7:0] r, input logic o,
                         input string tag, input logic [6:0] e3,
                         input logic [6:0] e2, input logic [6:0] e1,
                         input logic [6:0] e0);
    int n;
    @(negedge clk);
    load = 1'b1; res = r; ovfl = o;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    chk({tag, "_busy_len"}, n, 32'd9);
    expect_digits(tag, e3, e2, e1, e0);
  endtask

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; res = 8'd0; ovfl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    expect_digits("post_rst", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    do_load(8'h7B, 1'b0, "p123", 7'h7F, 7'h79, 7'h24, 7'h30);
    do_load(8'h80, 1'b0, "m128", 7'h3F, 7'h79, 7'h24, 7'h00);
    do_load(8'hF9, 1'b0, "m7",   7'h3F, 7'h7F, 7'h7F, 7'h78);
    do_load(8'h05, 1'b1, "ovf",  7'h7F, 7'h06, 7'h2F, 7'h2F);
    do_load(8'h7F, 1'b0, "p127", 7'h7F, 7'h79, 7'h24, 7'h78);
    do_load(8'h00, 1'b0, "zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // Second load lands while busy and must be dropped.
    @(negedge clk);
    load = 1'b1; res = 8'h2A;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; res = 8'h01;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    chk("ign_busy_len", n, 32'd6);
    expect_digits("ign", 7'h7F, 7'h7F, 7'h19, 7'h24);

    // Reset mid-conversion aborts and restores "   0".
    @(negedge clk);
    load = 1'b1; res = 8'h7B;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'hF);
    rst = 1'b0;
    expect_digits("abort", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    repeat (12) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
